// File: rtl/core_inst_sequencer.sv
// On-chip instruction sequencer for the core: weight fill, PE load, activation stream,
// OFIFO-to-psum accumulation per kernel offset, then a psum readout sweep.
module core_inst_sequencer #(
   parameter int unsigned ROW      = 8,
   parameter int unsigned COL      = 8,
   parameter int unsigned IN_W     = 6,
   parameter int unsigned K_W      = 3,
   parameter int unsigned O_W      = 4,
   parameter int unsigned WGT_BASE = 1024,
   parameter int unsigned GAP      = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        ofifo_valid_i,
   output logic [63:0] inst_o,
   output logic        core_rst_o,
   output logic        busy_o,
   output logic        rd_valid_o,
   output logic [3:0]  rd_idx_o,
   output logic        done_o,
   output logic        pop_overflow_o
);

   localparam int unsigned LenNij   = IN_W * IN_W;
   localparam int unsigned LenKij   = K_W * K_W;
   localparam int unsigned LenOnij  = O_W * O_W;
   localparam int unsigned LenKrst  = 11;
   localparam int unsigned LenWL0   = COL + 1;
   localparam int unsigned LenWLoad = 1 + COL + ROW;
   localparam int unsigned LenExec  = 1 + LenNij + COL + ROW;
   localparam int unsigned LenDrain = 4;
   localparam int unsigned LenRead  = LenOnij + 1;

   localparam logic [63:0] IdleWord = 64'h0000_0001_000C_0000;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StKrst  = 3'd1;
   localparam logic [2:0] StWL0   = 3'd2;
   localparam logic [2:0] StWLoad = 3'd3;
   localparam logic [2:0] StGap   = 3'd4;
   localparam logic [2:0] StExec  = 3'd5;
   localparam logic [2:0] StDrain = 3'd6;
   localparam logic [2:0] StRead  = 3'd7;

   logic [2:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  kij_q, kij_d;
   logic [7:0]  n_q, n_d;
   logic [63:0] inst_q, inst_d;
   logic        core_rst_q, core_rst_d;
   logic        busy_q, busy_d;
   logic        rd_valid_q, rd_valid_d;
   logic [3:0]  rd_idx_q, rd_idx_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;

   logic [7:0]  phase_last;
   logic        end_phase;
   logic [7:0]  w_off;
   logic [7:0]  n_col, n_row, kx, ky, ox, oy;
   logic        in_range, pop_ok;

   always_comb begin
      case (state_q)
         StKrst:  phase_last = 8'(LenKrst - 1);
         StWL0:   phase_last = 8'(LenWL0 - 1);
         StWLoad: phase_last = 8'(LenWLoad - 1);
         StGap:   phase_last = 8'(GAP - 1);
         StExec:  phase_last = 8'(LenExec - 1);
         StDrain: phase_last = 8'(LenDrain - 1);
         StRead:  phase_last = 8'(LenRead - 1);
         default: phase_last = 8'd0;
      endcase
      end_phase = (cnt_q == phase_last);
   end

   // Output-index mapping for the current pop: shift by the kernel offset of this kij.
   always_comb begin
      n_col    = n_q % 8'(IN_W);
      n_row    = n_q / 8'(IN_W);
      kx       = 8'(kij_q) % 8'(K_W);
      ky       = 8'(kij_q) / 8'(K_W);
      ox       = n_col - kx;
      oy       = n_row - ky;
      in_range = (n_q < 8'(LenNij));
      pop_ok   = in_range && (n_col >= kx) && (n_row >= ky) &&
                 (ox < 8'(O_W)) && (oy < 8'(O_W));
      w_off    = (cnt_q < 8'(COL - 1)) ? cnt_q : 8'(COL - 1);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = end_phase ? 8'd0 : cnt_q + 8'd1;
      kij_d      = kij_q;
      n_d        = n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      core_rst_d = 1'b0;
      rd_valid_d = 1'b0;
      rd_idx_d   = rd_idx_q;
      inst_d     = IdleWord;

      case (state_q)
         StIdle: begin
            cnt_d = 8'd0;
            if (start_i) begin
               state_d = StKrst;
               busy_d  = 1'b1;
               kij_d   = 4'd0;
               ovf_d   = 1'b0;
            end
         end
         StKrst: begin
            core_rst_d = (cnt_q != 8'(LenKrst - 1));
            if (end_phase) state_d = StWL0;
         end
         StWL0: begin
            inst_d[19]   = 1'b0;
            inst_d[17:7] = 11'(WGT_BASE) + 11'(COL) * 11'(kij_q) + 11'(w_off);
            inst_d[2]    = (cnt_q != 8'd0);
            if (end_phase) state_d = StWLoad;
         end
         StWLoad: begin
            inst_d[3] = 1'b1;
            inst_d[0] = (cnt_q != 8'd0);
            if (end_phase) state_d = StGap;
         end
         StGap: begin
            if (end_phase) begin
               state_d = StExec;
               n_d     = 8'd0;
            end
         end
         StExec: begin
            if (cnt_q <= 8'(LenNij)) begin
               inst_d[19]   = 1'b0;
               inst_d[17:7] = 11'(cnt_q);
               inst_d[3]    = 1'b1;
               inst_d[2]    = 1'b1;
               inst_d[1]    = (cnt_q != 8'd0);
            end
            if (end_phase) state_d = StDrain;
         end
         StDrain: begin
            if (end_phase) begin
               kij_d   = kij_q + 4'd1;
               state_d = (kij_q == 4'(LenKij - 1)) ? StRead : StKrst;
            end
         end
         StRead: begin
            if (cnt_q < 8'(LenOnij)) begin
               inst_d[34]    = 1'b1;
               inst_d[32]    = 1'b0;
               inst_d[30:20] = 11'(cnt_q);
            end
            if (cnt_q != 8'd0) begin
               rd_valid_d = 1'b1;
               rd_idx_d   = 4'(cnt_q - 8'd1);
            end
            if (end_phase) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Pops overlay the xmem/L0 fields; only the psum-side bits and ofifo_rd change.
      if ((state_q == StExec || state_q == StDrain) && ofifo_valid_i) begin
         inst_d[6]  = 1'b1;
         inst_d[34] = (kij_q == 4'd0);
         inst_d[33] = (kij_q != 4'd0);
         if (n_q != 8'hFF) n_d = n_q + 8'd1;
         if (pop_ok) begin
            inst_d[32]    = 1'b0;
            inst_d[31]    = 1'b1;
            inst_d[30:20] = 11'(ox + 8'(O_W) * oy);
         end
         if (!in_range) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         kij_q      <= 4'd0;
         n_q        <= 8'd0;
         inst_q     <= IdleWord;
         core_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= 4'd0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         kij_q      <= kij_d;
         n_q        <= n_d;
         inst_q     <= inst_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         rd_idx_q   <= rd_idx_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign inst_o         = inst_q;
   assign core_rst_o     = core_rst_q;
   assign busy_o         = busy_q;
   assign rd_valid_o     = rd_valid_q;
   assign rd_idx_o       = rd_idx_q;
   assign done_o         = done_q;
   assign pop_overflow_o = ovf_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: phase timing, instruction words, pop mapping,
// overflow, mid-run reset and readout beats.
module tb_core_inst_sequencer;

   localparam logic [63:0] Idle = 64'h0000_0001_000C_0000;

   logic        clk = 1'b0;
   logic        reset, start, ofifo_valid;
   logic [63:0] inst;
   logic        core_rst, busy, rd_valid, done, pop_overflow;
   logic [3:0]  rd_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int k;
   int rd_cnt, wr_cnt, wr4_cnt, pops, early_done, ph, kj;

   core_inst_sequencer dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .start_i        (start),
      .ofifo_valid_i  (ofifo_valid),
      .inst_o         (inst),
      .core_rst_o     (core_rst),
      .busy_o         (busy),
      .rd_valid_o     (rd_valid),
      .rd_idx_o       (rd_idx),
      .done_o         (done),
      .pop_overflow_o (pop_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, k);
      end
   endtask

   // {sfu_passthrough, acc, CEN_pmem, WEN_pmem, A_pmem, ofifo_rd}
   function automatic logic [63:0] pf(input logic [63:0] w);
      return 64'({w[34:31], w[30:20], w[6]});
   endfunction

   function automatic logic [63:0] pe(input logic s, input logic a, input logic c, input logic wn,
                                      input logic [10:0] addr, input logic rd);
      return 64'({s, a, c, wn, addr, rd});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
   endtask

   task automatic to_cycle(input int t);
      while (k < t) tick();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ofifo_valid = 1'b0;
      k = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) tick();
      check("idle_inst", inst, Idle);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_core_rst", 64'(core_rst), 64'd0);
      check("idle_ovf", 64'(pop_overflow), 64'd0);
      check("idle_rd_valid", 64'(rd_valid), 64'd0);

      // Run 1: no pops, timing and word checks.
      do_start();
      check("accept_busy", 64'(busy), 64'd1);
      check("accept_inst", inst, Idle);
      to_cycle(1);
      check("krst_first", 64'(core_rst), 64'd1);
      to_cycle(10);
      check("krst_c9", 64'(core_rst), 64'd1);
      to_cycle(11);
      check("krst_c10", 64'(core_rst), 64'd0);
      check("krst_c10_inst", inst, Idle);
      to_cycle(12);
      check("wl0_c0", inst, 64'h0000_0001_0006_0000);
      to_cycle(13);
      check("wl0_c1", inst, 64'h0000_0001_0006_0084);
      to_cycle(20);
      check("wl0_c8", inst, 64'h0000_0001_0006_0384);
      to_cycle(21);
      check("wload_c0", inst, 64'h0000_0001_000C_0008);
      to_cycle(22);
      check("wload_c1", inst, 64'h0000_0001_000C_0009);
      to_cycle(48);
      check("exec_e0", inst, 64'h0000_0001_0004_000C);
      to_cycle(49);
      check("exec_e1", inst, 64'h0000_0001_0004_008E);
      to_cycle(84);
      check("exec_e36", inst, 64'h0000_0001_0004_120E);
      to_cycle(85);
      check("exec_e37", inst, Idle);
      to_cycle(220);
      check("wl0_kij2", inst, 64'h0000_0001_0006_0800);
      to_cycle(300);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ignored_busy", 64'(busy), 64'd1);
      rd_cnt = 0;
      early_done = 0;
      while (k < 953) begin
         tick();
         if (done && k < 953) early_done = 1;
         if (rd_valid) begin
            check("r1_rd_idx", 64'(rd_idx), 64'(rd_cnt));
            rd_cnt++;
         end
         if (k == 937) check("read_r0", inst, 64'h0000_0004_000C_0000);
         if (k == 938) check("read_r1", inst, 64'h0000_0004_001C_0000);
      end
      check("r1_done_at_953", 64'(done), 64'd1);
      check("r1_busy_at_done", 64'(busy), 64'd0);
      check("r1_early_done", 64'(early_done), 64'd0);
      check("r1_beats", 64'(rd_cnt), 64'd16);
      tick();
      check("r1_done_pulse", 64'(done), 64'd0);
      check("r1_post_inst", inst, Idle);

      // Run 2: reset during EXEC.
      do_start();
      to_cycle(60);
      check("r2_exec_active", 64'(inst[1]), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("r2_reset_inst", inst, Idle);
      check("r2_reset_busy", 64'(busy), 64'd0);
      check("r2_reset_core_rst", 64'(core_rst), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) tick();
      check("r2_after_reset", inst, Idle);

      // Run 3: 36 pops per kij from e=17, a 37th pop in kij 8.
      do_start();
      rd_cnt = 0;
      wr_cnt = 0;
      wr4_cnt = 0;
      pops = 0;
      early_done = 0;
      while (k < 953) begin
         ph = k % 104;
         kj = k / 104;
         ofifo_valid = (kj < 9) && (ph >= 64) && (ph <= ((kj == 8) ? 100 : 99));
         tick();
         if (inst[6]) pops++;
         if (!inst[32] && inst[31]) begin
            wr_cnt++;
            if (inst[33] && k > 416 && k <= 520) wr4_cnt++;
         end
         if (done && k < 953) early_done = 1;
         if (rd_valid) begin
            check("r3_rd_idx", 64'(rd_idx), 64'(rd_cnt));
            rd_cnt++;
         end
         case (k)
            64:  check("k0_nopop", pf(inst), pe(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0));
            65:  check("k0_n0", pf(inst), pe(1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 1'b1));
            86:  check("k0_n21", pf(inst), pe(1'b1, 1'b0, 1'b0, 1'b1, 11'd15, 1'b1));
            100: check("k0_n35", pf(inst), pe(1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1));
            481: check("k4_n0", pf(inst), pe(1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 1'b1));
            488: check("k4_n7", pf(inst), pe(1'b0, 1'b1, 1'b0, 1'b1, 11'd0, 1'b1));
            910: check("k8_n13", pf(inst), pe(1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 1'b1));
            911: check("k8_n14", pf(inst), pe(1'b0, 1'b1, 1'b0, 1'b1, 11'd0, 1'b1));
            932: begin
               check("k8_n35", pf(inst), pe(1'b0, 1'b1, 1'b0, 1'b1, 11'd15, 1'b1));
               check("ovf_before", 64'(pop_overflow), 64'd0);
            end
            933: begin
               check("k8_n36", pf(inst), pe(1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 1'b1));
               check("ovf_set", 64'(pop_overflow), 64'd1);
            end
            default: ;
         endcase
      end
      ofifo_valid = 1'b0;
      check("r3_done_at_953", 64'(done), 64'd1);
      check("r3_early_done", 64'(early_done), 64'd0);
      check("r3_beats", 64'(rd_cnt), 64'd16);
      check("r3_pops", 64'(pops), 64'd325);
      check("r3_writes", 64'(wr_cnt), 64'd144);
      check("r3_kij4_acc_writes", 64'(wr4_cnt), 64'd16);
      repeat (3) tick();
      check("ovf_sticky", 64'(pop_overflow), 64'd1);
      check("r3_idle_busy", 64'(busy), 64'd0);

      // Run 4: new start clears the sticky overflow.
      do_start();
      check("ovf_cleared", 64'(pop_overflow), 64'd0);
      check("r4_busy", 64'(busy), 64'd1);
      to_cycle(5);
      reset = 1'b1;
      #3 reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
